// File: rtl/uart_rcvr.sv
// 8N1 serial receiver: oversampled start/data/stop recovery with a valid/ack
// host register and sticky framing/overrun flags.
module uart_rcvr #(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                 clk,
  input  logic                 bReset,
  input  logic                 Serial_in,
  output logic [WORD_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 err_frame,
  output logic                 err_overrun,
  input  logic                 err_clr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] WORD_LAST = BW'(WORD_SIZE - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic                 sync1_r;
  logic                 sync2_r;
  logic [2:0]           state_r;
  logic [CW-1:0]        cnt_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [WORD_SIZE-1:0] shift_r;
  logic [WORD_SIZE-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 err_frame_r;
  logic                 err_overrun_r;

  logic                 s_in_s;
  logic [2:0]           state_s;
  logic [CW-1:0]        cnt_s;
  logic [BW-1:0]        bit_cnt_s;
  logic [WORD_SIZE-1:0] shift_s;
  logic [WORD_SIZE-1:0] rx_data_s;
  logic                 rx_valid_s;
  logic                 err_frame_s;
  logic                 err_overrun_s;
  logic                 load_s;
  logic                 frame_bad_s;

  assign s_in_s      = sync2_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign err_frame   = err_frame_r;
  assign err_overrun = err_overrun_r;

  // Frame recovery: every decision is taken mid-bit on the synchronized line.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    load_s      = 1'b0;
    frame_bad_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (s_in_s == 1'b0) begin
          state_s = START;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s     = {CW{1'b0}};
          bit_cnt_s = {BW{1'b0}};
          if (s_in_s == 1'b0) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s   = {CW{1'b0}};
          shift_s = {s_in_s, shift_r[WORD_SIZE-1:1]};
          if (bit_cnt_r == WORD_LAST) begin
            bit_cnt_s = {BW{1'b0}};
            state_s   = STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + BW'(1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s = {CW{1'b0}};
          if (s_in_s == 1'b1) begin
            load_s  = 1'b1;
            state_s = IDLE;
          end else begin
            frame_bad_s = 1'b1;
            state_s     = BREAK;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      BREAK: begin
        // A line held low must return high before another start is accepted.
        if (s_in_s == 1'b1) begin
          state_s = IDLE;
        end else begin
          state_s = BREAK;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Host register: a load beats a same-cycle ack; error events beat err_clr.
  always_comb begin
    rx_data_s     = rx_data_r;
    rx_valid_s    = rx_valid_r;
    err_frame_s   = err_frame_r;
    err_overrun_s = err_overrun_r;
    if (load_s) begin
      rx_data_s  = shift_r;
      rx_valid_s = 1'b1;
    end else if (rx_ack) begin
      rx_valid_s = 1'b0;
    end else begin
      rx_valid_s = rx_valid_r;
    end
    if (load_s && rx_valid_r && !rx_ack) begin
      err_overrun_s = 1'b1;
    end else if (err_clr) begin
      err_overrun_s = 1'b0;
    end else begin
      err_overrun_s = err_overrun_r;
    end
    if (frame_bad_s) begin
      err_frame_s = 1'b1;
    end else if (err_clr) begin
      err_frame_s = 1'b0;
    end else begin
      err_frame_s = err_frame_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!bReset) begin
      sync1_r       <= 1'b1;
      sync2_r       <= 1'b1;
      state_r       <= IDLE;
      cnt_r         <= {CW{1'b0}};
      bit_cnt_r     <= {BW{1'b0}};
      shift_r       <= {WORD_SIZE{1'b0}};
      rx_data_r     <= {WORD_SIZE{1'b0}};
      rx_valid_r    <= 1'b0;
      err_frame_r   <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      sync1_r       <= Serial_in;
      sync2_r       <= sync1_r;
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      bit_cnt_r     <= bit_cnt_s;
      shift_r       <= shift_s;
      rx_data_r     <= rx_data_s;
      rx_valid_r    <= rx_valid_s;
      err_frame_r   <= err_frame_s;
      err_overrun_r <= err_overrun_s;
    end
  end

endmodule

// File: tb/tb_uart_rcvr.sv
// Directed bench for uart_rcvr: expected words go into a scoreboard queue and a
// monitor process pops and compares each word the receiver presents.
module tb_uart_rcvr;

  logic       clk = 1'b0;
  logic       bReset;
  logic       Serial_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       err_frame;
  logic       err_overrun;
  logic       err_clr;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         load_cyc = 0;
  int         t0;
  int         lat;
  logic [7:0] exp_q[$];

  uart_rcvr #(.WORD_SIZE(8), .CLKS_PER_BIT(8)) dut (
    .clk(clk), .bReset(bReset), .Serial_in(Serial_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .err_frame(err_frame), .err_overrun(err_overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Line is left at the stop-bit level so a framing test can keep it low.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    Serial_in = 1'b0;
    wait_cyc(8);
    for (int i = 0; i < 8; i++) begin
      Serial_in = d[i];
      wait_cyc(8);
    end
    Serial_in = stop_bit;
    wait_cyc(8);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    wait_cyc(1);
    rx_ack = 1'b0;
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
  endtask

  // Monitor: a new word is a rising rx_valid or a data change while valid.
  initial begin
    logic       pv;
    logic [7:0] pd;
    pv = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge clk);
      if (bReset && rx_valid && (!pv || rx_data != pd)) begin
        load_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %02h with nothing expected", rx_data);
        end else begin
          check("rx_data_sb", rx_data, exp_q.pop_front());
        end
      end
      pv = rx_valid;
      pd = rx_data;
    end
  end

  initial begin
    bReset = 1'b0;
    Serial_in = 1'b1;
    rx_ack = 1'b0;
    err_clr = 1'b0;
    wait_cyc(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_err_frame", err_frame, 1'b0);
    check("rst_err_overrun", err_overrun, 1'b0);
    bReset = 1'b1;
    wait_cyc(20);

    // Single frame 0xA5 with latency and ack.
    exp_q.push_back(8'hA5);
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    wait_cyc(2);
    lat = load_cyc - t0;
    total++;
    if (lat < 77 || lat > 79) begin
      bad++;
      $display("FAIL latency: got %0d cycles expected 77..79", lat);
    end
    check("a5_valid", rx_valid, 1'b1);
    check("a5_err_frame", err_frame, 1'b0);
    check("a5_err_overrun", err_overrun, 1'b0);
    ack_pulse();
    check("a5_ack_clears_valid", rx_valid, 1'b0);

    // Back-to-back 0x3C then 0xFF, first acked during the second frame.
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hFF);
    send_frame(8'h3C, 1'b1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_cyc(20);
        ack_pulse();
      end
    join
    wait_cyc(2);
    check("b2b_valid", rx_valid, 1'b1);
    check("b2b_data", rx_data, 8'hFF);
    check("b2b_no_overrun", err_overrun, 1'b0);
    ack_pulse();

    // Overrun: 0x12 then 0x34 without ack.
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_cyc(2);
    check("ovr_data", rx_data, 8'h34);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_flag", err_overrun, 1'b1);
    clr_pulse();
    check("ovr_cleared", err_overrun, 1'b0);
    check("ovr_valid_kept", rx_valid, 1'b1);
    ack_pulse();
    check("ovr_acked", rx_valid, 1'b0);

    // Framing error with a long break, then a good frame.
    send_frame(8'h55, 1'b0);
    wait_cyc(40);
    check("fe_flag", err_frame, 1'b1);
    check("fe_valid_unchanged", rx_valid, 1'b0);
    check("fe_no_overrun", err_overrun, 1'b0);
    Serial_in = 1'b1;
    wait_cyc(20);
    check("fe_break_no_frame", rx_valid, 1'b0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_cyc(2);
    check("fe_next_valid", rx_valid, 1'b1);
    check("fe_next_data", rx_data, 8'h81);
    check("fe_sticky", err_frame, 1'b1);
    clr_pulse();
    check("fe_cleared", err_frame, 1'b0);

    // Short low glitch on an idle line is rejected.
    Serial_in = 1'b0;
    wait_cyc(2);
    Serial_in = 1'b1;
    wait_cyc(30);
    check("glitch_valid", rx_valid, 1'b1);
    check("glitch_data", rx_data, 8'h81);
    check("glitch_err_frame", err_frame, 1'b0);
    check("glitch_err_overrun", err_overrun, 1'b0);

    // Reset during data bit 4 of a frame, then a clean frame.
    fork
      send_frame(8'hF0, 1'b1);
      begin
        wait_cyc(8 + 32 + 3);
        bReset = 1'b0;
        wait_cyc(1);
        check("mid_rst_rx_data", rx_data, 8'h00);
        check("mid_rst_rx_valid", rx_valid, 1'b0);
        check("mid_rst_err_frame", err_frame, 1'b0);
        check("mid_rst_err_overrun", err_overrun, 1'b0);
        bReset = 1'b1;
      end
    join
    wait_cyc(10);
    check("post_rst_idle", rx_valid, 1'b0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    wait_cyc(2);
    check("c3_valid", rx_valid, 1'b1);
    check("c3_data", rx_data, 8'hC3);
    check("c3_err_frame", err_frame, 1'b0);
    check("c3_err_overrun", err_overrun, 1'b0);
    wait_cyc(4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rcvr.md
Name: uart_rcvr

Overview:
- Serial receiver, directly downstream of the system's UART transmitter; consumes its Serial_out line.
- Recovers 8N1 frames: start bit 0, WORD_SIZE data bits LSB first, one stop bit 1, idle line high.
- Oversamples each bit CLKS_PER_BIT times on the system clock.
- Presents each received word to a host through a valid/ack register interface, with sticky framing and overrun flags.

Parameters:
- WORD_SIZE, 8: data bits per frame.
- CLKS_PER_BIT, 8: clk cycles per bit time. Must be even and >= 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- bReset  input  1  synchronous, active-low reset.
- Serial_in  input  1  asynchronous serial line (transmitter's Serial_out).
- rx_data  output  WORD_SIZE  last correctly framed word.
- rx_valid  output  1  rx_data holds an unread word.
- rx_ack  input  1  host has consumed rx_data.
- err_frame  output  1  sticky; stop bit sampled as 0.
- err_overrun  output  1  sticky; unread word was overwritten.
- err_clr  input  1  clears both error flags.

Behaviour:
- Reset, sampled on clk while bReset=0:
  - state=IDLE; rx_data=0; rx_valid=0; err_frame=0; err_overrun=0.
  - Sample and bit counters = 0; shift register = 0; both synchronizer flops = 1.
- Serial_in passes through a 2-flop synchronizer; all decisions use the synchronized value s_in.
- IDLE: on s_in=0, go to START with sample counter cleared.
- START:
  - Count to CLKS_PER_BIT/2-1 (mid start bit).
  - At that count: if s_in=0, go to DATA with counters cleared; if s_in=1, treat as a glitch and return to IDLE with no flags.
- DATA:
  - Count to CLKS_PER_BIT-1 (mid bit), then sample s_in.
  - Shift the sample into the shift register MSB, shifting right, so the LSB-first line order lands correctly.
  - Increment the bit counter. After bit WORD_SIZE-1, go to STOP.
- STOP: at CLKS_PER_BIT-1, sample s_in.
  - s_in=1 (good frame):
    - Load rx_data from the shift register; rx_valid=1.
    - If rx_valid was already 1 and rx_ack is not asserted this cycle, set err_overrun=1; the new word still replaces the old one.
    - Return to IDLE.
  - s_in=0 (framing error): set err_frame=1; rx_data and rx_valid unchanged; go to BREAK.
- BREAK: wait until s_in=1, then go to IDLE. A held-low line never re-triggers a start.
- Handshake:
  - rx_valid=1 and rx_ack=1 clears rx_valid on the next edge.
  - rx_ack while rx_valid=0 is ignored.
  - Same-cycle load and ack: the load wins, rx_valid stays 1, no overrun.
- err_clr=1 clears both flags on the next edge. If err_clr coincides with a new error event, the flag ends up set.
- Latency: rx_valid rises 2 + CLKS_PER_BIT/2 + (WORD_SIZE+1)*CLKS_PER_BIT cycles (+/-1) after the falling edge of the start bit at Serial_in. With defaults this is 78.
- Counters size to hold CLKS_PER_BIT-1 and WORD_SIZE-1; they never wrap mid-state.
- Reset asserted mid-frame aborts the frame in one cycle: state IDLE, no flags.
- Back-to-back frames, whose start bit immediately follows a stop bit, are received with no lost word.

Test Plan:
- Defaults. Idle high 20 cycles, then send frame 0xA5 (line: 0,1,0,1,0,0,1,0,1,1), 8 clk per bit -> rx_valid=1 at 78+/-1 cycles, rx_data=0xA5, no flags; rx_ack one cycle -> rx_valid=0 next cycle.
- Send 0x3C then 0xFF back-to-back; ack 0x3C before the second stop bit -> two valid events, rx_data=0x3C then 0xFF, err_overrun=0.
- Send 0x12 and 0x34 with no ack -> rx_data=0x34, rx_valid=1, err_overrun=1; err_clr one cycle -> err_overrun=0, rx_valid still 1.
- Send 0x55 with the stop bit forced 0, then hold the line low 40 cycles, then release high -> err_frame=1, rx_valid unchanged, no further frame or flag; next frame 0x81 received correctly.
- 2-cycle low glitch on the idle line -> state returns to IDLE, no rx_valid, no flags.
- Assert bReset=0 during bit 4 of a frame -> all outputs 0 next cycle; after release, frame 0xC3 received correctly.
